// File: rtl/detector_stream_driver.sv
// ============================================================================
// Module   : detector_stream_driver
// Purpose  : Holds one host-loaded frame and streams it into the object
//            detector: repeated training passes until the detector reports
//            training complete, then a single inference pass whose returned
//            pixels are captured into a host-readable result buffer.
// Options  : STREAM_GAP_EN - when defined, each streamed pixel is followed
//            by one idle cycle (o_img_mem_wr low, data held).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_stream_driver #(
    parameter int NUM_PIXELS       = 100,
    parameter int ADDR_W           = 8,
    parameter int MAX_TRAIN_PASSES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_wr,
    input  logic [7:0]        i_load_data,
    input  logic              i_start,
    output logic              o_mode,
    output logic              o_img_mem_wr,
    output logic [7:0]        o_img_data,
    input  logic              i_done_training,
    input  logic              i_det_valid,
    input  logic [7:0]        i_det_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_train_err
);

    localparam int                PASS_W     = $clog2(MAX_TRAIN_PASSES + 1);
    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CAP_FULL   = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0]   CAP_LAST   = (ADDR_W + 1)'(NUM_PIXELS - 1);
    localparam logic [ADDR_W:0]   CAP_ONE    = (ADDR_W + 1)'(1);
    localparam logic [PASS_W-1:0] PASS_LIMIT = PASS_W'(MAX_TRAIN_PASSES);
    localparam logic [PASS_W-1:0] PASS_ONE   = PASS_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRAIN = 3'd1,
        CHECK = 3'd2,
        INFER = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [7:0]          frame_mem  [DEPTH];
    logic [7:0]          result_mem [DEPTH];

    logic [ADDR_W-1:0]   load_ptr;
    logic [ADDR_W-1:0]   stream_ptr;
    logic [ADDR_W:0]     cap_ptr;
    logic [PASS_W-1:0]   pass_cnt;
    logic                infer_first;

    logic                streaming;
    logic                emit;
    logic                advance;
    logic                pass_end;
    logic                cap_en;
    logic                cap_last;

    assign streaming = (state == TRAIN) || (state == INFER);

`ifdef STREAM_GAP_EN
    logic gap_phase;

    // Alternate pixel / idle slots while streaming; every pass starts on a pixel slot.
    always_ff @(posedge i_clk) begin
        if (i_reset || !streaming) begin
            gap_phase <= 1'b0;
        end else begin
            gap_phase <= ~gap_phase;
        end
    end

    assign emit    = streaming && !gap_phase;
    assign advance = streaming &&  gap_phase;
`else
    assign emit    = streaming;
    assign advance = streaming;
`endif

    assign pass_end = advance && (stream_ptr == LAST_PIX);

    // The first INFER cycle carries the echo of the last training pixel, so it is never captured.
    assign cap_en   = (((state == INFER) && !infer_first) || (state == DRAIN))
                      && i_det_valid && (cap_ptr != CAP_FULL);
    assign cap_last = cap_en && (cap_ptr == CAP_LAST);

    assign o_busy   = (state != IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing: train passes, pass-limit check, one inference pass, drain.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (i_start) next_state = TRAIN;
            TRAIN: if (pass_end) next_state = CHECK;
            CHECK: begin
                if (i_done_training) begin
                    next_state = INFER;
                end else if (pass_cnt == PASS_LIMIT) begin
                    next_state = IDLE;
                end else begin
                    next_state = TRAIN;
                end
            end
            INFER: if (pass_end) next_state = DRAIN;
            DRAIN: if (cap_ptr == CAP_FULL) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pointers, counters and registered outputs; mode only flips on cycles with no write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            load_ptr     <= '0;
            stream_ptr   <= '0;
            cap_ptr      <= '0;
            pass_cnt     <= '0;
            infer_first  <= 1'b0;
            o_mode       <= 1'b0;
            o_img_mem_wr <= 1'b0;
            o_img_data   <= 8'd0;
            o_rd_data    <= 8'd0;
            o_frame_done <= 1'b0;
            o_train_err  <= 1'b0;
        end else begin
            o_img_mem_wr <= emit;
            o_frame_done <= cap_last;
            o_rd_data    <= result_mem[i_rd_addr];
            infer_first  <= 1'b0;

            if (emit) begin
                o_img_data <= frame_mem[stream_ptr];
            end
            if (advance) begin
                stream_ptr <= pass_end ? '0 : stream_ptr + PTR_ONE;
            end
            if (cap_en) begin
                cap_ptr <= cap_ptr + CAP_ONE;
            end

            unique case (state)
                IDLE: begin
                    if (i_load_wr) begin
                        load_ptr <= (load_ptr == LAST_PIX) ? '0 : load_ptr + PTR_ONE;
                    end
                    if (i_start) begin
                        stream_ptr  <= '0;
                        pass_cnt    <= '0;
                        o_train_err <= 1'b0;
                        o_mode      <= 1'b1;
                    end
                end
                TRAIN: begin
                    if (pass_end) begin
                        pass_cnt <= pass_cnt + PASS_ONE;
                    end
                end
                CHECK: begin
                    if (i_done_training) begin
                        o_mode      <= 1'b0;
                        cap_ptr     <= '0;
                        infer_first <= 1'b1;
                    end else if (pass_cnt == PASS_LIMIT) begin
                        o_train_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer writes: host frame loads in IDLE, detector results during capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset && (state == IDLE) && i_load_wr) begin
            frame_mem[load_ptr] <= i_load_data;
        end
        if (!i_reset && cap_en) begin
            result_mem[cap_ptr[ADDR_W-1:0]] <= i_det_data;
        end
    end

endmodule

`default_nettype wire
